versa_gpio_wr_guard: RTL and testbench
======================================

Name: versa_gpio_wr_guard

Overview:
- Hardware monitor on the GPIO write (actuation) path. It is the output-side counterpart of the GPIO read monitor.
- Permits writes to GPIO registers only from CPU code executing inside an authorized executable region [ER_min, ER_max]. Entry must follow the auth handler.
- Counts legal actuations and latches an exec_flag when ER completes cleanly.
- Asserts viol_reset on any violation. viol_reset feeds the core reset OR-tree alongside the other VRASED/VERSA monitors.

Parameters:
- AUTH_HANDLER, 16'hA0BE, PC value that arms the guard.
- RESET_HANDLER, 16'h0000, PC value that clears a violation.
- GPIO_BASE, 16'h0018, first guarded GPIO address.
- GPIO_SIZE, 16'h0020, guarded bytes; range is [GPIO_BASE, GPIO_BASE+GPIO_SIZE-1].
- CNT_W, 8, width of wr_cnt.
- MAX_ER_CYCLES, 16'hFFFF, maximum cycles allowed in RUN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pc  input  16  current CPU program counter
- data_addr  input  16  CPU data address
- data_wr  input  1  CPU data write strobe
- dma_addr  input  16  DMA address
- dma_en  input  1  DMA access strobe (read or write)
- ER_min  input  16  ER first instruction address
- ER_max  input  16  ER exit instruction address
- wr_cnt  output  CNT_W  legal GPIO writes in last/current ER run
- exec_flag  output  1  1 = last ER run completed without violation
- viol_reset  output  1  violation reset request

Behaviour:
- One clock, clk. reset_n is asynchronous, active-low.
- During reset_n=0: state=VIOL, viol_reset=1, exec_flag=0, wr_cnt=0, cycle counter=0.
- All outputs are registered and update on the clk edge that changes state. There is no combinational path from inputs to outputs.
- Decodes:
  - gw_cpu = data_wr && data_addr in GPIO range.
  - gw_dma = dma_en && dma_addr in GPIO range. Any DMA access counts, reads included.
  - pc_in_ER = ER_min <= pc <= ER_max.
  - bad_ER = (ER_min >= ER_max) || ER_min==RESET_HANDLER || ER_max==RESET_HANDLER.
- States: IDLE=2'b00, AUTH=2'b01, RUN=2'b10, VIOL=2'b11. Conditions below are in priority order.
- Any state: bad_ER -> VIOL. Takes precedence over everything below.
- IDLE:
  - gw_cpu or gw_dma -> VIOL.
  - pc==AUTH_HANDLER -> AUTH, clear exec_flag.
  - else hold.
- AUTH:
  - gw_cpu or gw_dma -> VIOL. Writes are illegal even when pc==ER_min in this cycle.
  - pc==ER_min -> RUN, clear wr_cnt and cycle counter.
  - else hold.
- RUN:
  - gw_dma -> VIOL.
  - gw_cpu && !pc_in_ER -> VIOL.
  - !pc_in_ER -> VIOL (early exit or jump out).
  - cycle counter == MAX_ER_CYCLES and pc != ER_max -> VIOL.
  - pc==ER_max -> IDLE, exec_flag=1. A legal gw_cpu in the same cycle is still counted.
  - gw_cpu && pc_in_ER -> stay, wr_cnt+1.
  - Cycle counter increments every RUN cycle.
- VIOL:
  - viol_reset=1.
  - pc==RESET_HANDLER && !gw_cpu && !gw_dma && !bad_ER -> IDLE, viol_reset=0.
  - else hold.
- Entry into VIOL from any state, same edge: viol_reset=1, exec_flag=0, wr_cnt=0.
- wr_cnt:
  - Saturates at 2^CNT_W-1; never wraps.
  - Held after a clean exit until the next RUN entry.
- Cycle counter: 16 bits, saturating.
- reset_n asserted mid-RUN: immediate asynchronous return to the reset values, regardless of clk.
- ER_min/ER_max changing while in RUN: re-evaluated every cycle. The bad_ER and !pc_in_ER rules apply.

Test Plan:
- Reset release: hold reset_n=0 -> viol_reset=1, wr_cnt=0. Release, then drive pc=16'h0000 -> next edge viol_reset=0, state IDLE.
- Happy path:
  - Setup: ER_min=16'hE000, ER_max=16'hE100.
  - pc=16'hA0BE -> AUTH. pc=16'hE000 -> RUN.
  - Three data_wr at data_addr=16'h0021 with pc in 16'hE002..16'hE0F0 -> wr_cnt=3.
  - pc=16'hE100 -> IDLE, exec_flag=1, viol_reset=0.
- Unauthorized actuation: in IDLE, data_wr=1, data_addr=16'h0029 -> next edge viol_reset=1, exec_flag=0. Then pc=16'h0000 -> IDLE.
- DMA and early exit:
  - Case A: in RUN, dma_en=1, dma_addr=16'h0022 -> VIOL.
  - Case B: from a fresh run, in RUN drive pc=16'hD000 -> VIOL, wr_cnt=0, exec_flag=0.
- Timeout and saturation:
  - Timeout: MAX_ER_CYCLES=16; stay in RUN at pc=16'hE010 for 17 cycles -> VIOL on the 17th edge.
  - Saturation: CNT_W=2; issue 5 legal writes -> wr_cnt stays 3.
- Invalid ER: ER_min=16'hE100, ER_max=16'hE000 in any state -> VIOL. pc=16'h0000 does not clear VIOL until ER is valid.

Source files
------------

// File: rtl/versa_gpio_wr_guard_if.sv
// CPU data-bus, DMA and executable-region signals observed by the GPIO write guard.
// Pure wiring: no latency, no backpressure.
interface versa_gpio_wr_guard_if;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_wr;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic [15:0] ER_min;
    logic [15:0] ER_max;

    modport master (
        output pc, data_addr, data_wr, dma_addr, dma_en, ER_min, ER_max
    );

    modport slave (
        input  pc, data_addr, data_wr, dma_addr, dma_en, ER_min, ER_max
    );
endinterface

// File: rtl/versa_gpio_wr_guard.sv
// Guards GPIO writes: only code inside an authorised ER, entered via the auth handler, may actuate.
// Latency: outputs registered, one clk after the observed bus cycle; no combinational input->output path.
// Backpressure: none; a pure monitor that never stalls the CPU, it only requests a reset.
module versa_gpio_wr_guard #(
    parameter logic [15:0] AUTH_HANDLER  = 16'hA0BE,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [15:0] GPIO_BASE     = 16'h0018,
    parameter logic [15:0] GPIO_SIZE     = 16'h0020,
    parameter int unsigned CNT_W         = 8,
    parameter logic [15:0] MAX_ER_CYCLES = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    versa_gpio_wr_guard_if.slave    bus,
    output logic [CNT_W-1:0]        wr_cnt,
    output logic                    exec_flag,
    output logic                    viol_reset
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_AUTH = 2'b01,
        S_RUN  = 2'b10,
        S_VIOL = 2'b11
    } state_t;

    // 17-bit end bound so a range reaching 16'hFFFF does not wrap
    localparam logic [16:0]      GPIO_END = {1'b0, GPIO_BASE} + {1'b0, GPIO_SIZE};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic             r_exec, w_exec_nxt;
    logic             r_viol, w_viol_nxt;
    logic [15:0]      r_cyc, w_cyc_nxt;

    logic w_gw_cpu, w_gw_dma, w_pc_in_er, w_bad_er;

    assign w_gw_cpu   = bus.data_wr && (bus.data_addr >= GPIO_BASE)
                        && ({1'b0, bus.data_addr} < GPIO_END);
    assign w_gw_dma   = bus.dma_en && (bus.dma_addr >= GPIO_BASE)
                        && ({1'b0, bus.dma_addr} < GPIO_END);
    assign w_pc_in_er = (bus.pc >= bus.ER_min) && (bus.pc <= bus.ER_max);
    assign w_bad_er   = (bus.ER_min >= bus.ER_max) || (bus.ER_min == RESET_HANDLER)
                        || (bus.ER_max == RESET_HANDLER);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_exec_nxt   = r_exec;
        w_cyc_nxt    = r_cyc;
        if (w_bad_er) begin
            w_state_nxt = S_VIOL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gw_cpu || w_gw_dma) begin
                        w_state_nxt = S_VIOL;
                    end else if (bus.pc == AUTH_HANDLER) begin
                        w_state_nxt = S_AUTH;
                        w_exec_nxt  = 1'b0;
                    end
                end
                S_AUTH: begin
                    if (w_gw_cpu || w_gw_dma) begin
                        w_state_nxt = S_VIOL;
                    end else if (bus.pc == bus.ER_min) begin
                        w_state_nxt  = S_RUN;
                        w_wr_cnt_nxt = '0;
                        w_cyc_nxt    = '0;
                    end
                end
                S_RUN: begin
                    // an out-of-ER CPU write is covered by the plain out-of-ER exit
                    if (w_gw_dma || !w_pc_in_er) begin
                        w_state_nxt = S_VIOL;
                    end else if ((r_cyc == MAX_ER_CYCLES) && (bus.pc != bus.ER_max)) begin
                        w_state_nxt = S_VIOL;
                    end else begin
                        if (r_cyc != 16'hFFFF) begin
                            w_cyc_nxt = r_cyc + 16'd1;
                        end
                        if (w_gw_cpu && (r_wr_cnt != CNT_MAX)) begin
                            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                        end
                        if (bus.pc == bus.ER_max) begin
                            w_state_nxt = S_IDLE;
                            w_exec_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    if ((bus.pc == RESET_HANDLER) && !w_gw_cpu && !w_gw_dma) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
        if (w_state_nxt == S_VIOL) begin
            w_wr_cnt_nxt = '0;
            w_exec_nxt   = 1'b0;
        end
        w_viol_nxt = (w_state_nxt == S_VIOL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_VIOL;
            r_wr_cnt <= '0;
            r_exec   <= 1'b0;
            r_viol   <= 1'b1;
            r_cyc    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_exec   <= w_exec_nxt;
            r_viol   <= w_viol_nxt;
            r_cyc    <= w_cyc_nxt;
        end
    end

    assign wr_cnt     = r_wr_cnt;
    assign exec_flag  = r_exec;
    assign viol_reset = r_viol;

endmodule

// File: tb/tb_versa_gpio_wr_guard.sv
// Scoreboard bench for versa_gpio_wr_guard: default-parameter DUT (a) plus a short-timeout, 2-bit-counter DUT (b).
module tb_versa_gpio_wr_guard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] wr_cnt_a;
    logic       exec_a, viol_a;
    logic [1:0] wr_cnt_b;
    logic       exec_b, viol_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    versa_gpio_wr_guard_if bus_if ();

    versa_gpio_wr_guard dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus_if),
        .wr_cnt     (wr_cnt_a),
        .exec_flag  (exec_a),
        .viol_reset (viol_a)
    );

    versa_gpio_wr_guard #(.CNT_W(2), .MAX_ER_CYCLES(16'd16)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus_if),
        .wr_cnt     (wr_cnt_b),
        .exec_flag  (exec_b),
        .viol_reset (viol_b)
    );

    typedef struct {
        logic [15:0] pc;
        logic        wr;
        logic [15:0] addr;
        logic        den;
        logic [15:0] daddr;
        logic [15:0] emin;
        logic [15:0] emax;
        logic        viol;
        logic        exec;
        logic [7:0]  cnt;
    } row_t;

    typedef struct {
        logic       viol;
        logic       exec;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    function automatic row_t F(input logic [15:0] pc, input logic wr, input logic [15:0] addr,
                               input logic den, input logic [15:0] daddr,
                               input logic [15:0] emin, input logic [15:0] emax,
                               input logic viol, input logic exec, input logic [7:0] cnt);
        row_t r;
        r.pc = pc; r.wr = wr; r.addr = addr; r.den = den; r.daddr = daddr;
        r.emin = emin; r.emax = emax; r.viol = viol; r.exec = exec; r.cnt = cnt;
        return r;
    endfunction

    function automatic row_t R(input logic [15:0] pc, input logic viol, input logic exec,
                               input logic [7:0] cnt);
        return F(pc, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE000, 16'hE100, viol, exec, cnt);
    endfunction

    function automatic row_t W(input logic [15:0] pc, input logic [15:0] addr, input logic viol,
                               input logic exec, input logic [7:0] cnt);
        return F(pc, 1'b1, addr, 1'b0, 16'h0000, 16'hE000, 16'hE100, viol, exec, cnt);
    endfunction

    task automatic drive_row(input row_t r);
        exp_t e;
        bus_if.pc        = r.pc;
        bus_if.data_wr   = r.wr;
        bus_if.data_addr = r.addr;
        bus_if.dma_en    = r.den;
        bus_if.dma_addr  = r.daddr;
        bus_if.ER_min    = r.emin;
        bus_if.ER_max    = r.emax;
        e.viol = r.viol; e.exec = r.exec; e.cnt = r.cnt;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        drive_row(R(16'h1234, 1'b1, 1'b0, 8'd0));
        #1 reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        e = sb.pop_front();
        checks += 4;
        if (viol_a !== e.viol) begin failures++; $display("FAIL reset_hold viol_reset got=%b exp=%b", viol_a, e.viol); end
        if (exec_a !== e.exec) begin failures++; $display("FAIL reset_hold exec_flag got=%b exp=%b", exec_a, e.exec); end
        if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL reset_hold wr_cnt got=%0d exp=%0d", wr_cnt_a, e.cnt); end
        if (viol_b !== e.viol) begin failures++; $display("FAIL reset_hold_b viol_reset got=%b exp=%b", viol_b, e.viol); end
        reset_n = 1'b1;
        rows.push_back(R(16'h1234, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL reset[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL reset[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL reset[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    task automatic test_happy_path();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE002, 16'h0021, 1'b0, 1'b0, 8'd1));
        rows.push_back(R(16'hE050, 1'b0, 1'b0, 8'd1));
        rows.push_back(W(16'hE080, 16'h0021, 1'b0, 1'b0, 8'd2));
        rows.push_back(W(16'hE0F0, 16'h0021, 1'b0, 1'b0, 8'd3));
        rows.push_back(R(16'hE100, 1'b0, 1'b1, 8'd3));
        rows.push_back(R(16'h1000, 1'b0, 1'b1, 8'd3));
        rows.push_back(W(16'h1000, 16'h0038, 1'b0, 1'b1, 8'd3));
        rows.push_back(W(16'h1000, 16'h0017, 1'b0, 1'b1, 8'd3));
        rows.push_back(F(16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0038, 16'hE000, 16'hE100, 1'b0, 1'b1, 8'd3));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL happy[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL happy[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL happy[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    task automatic test_unauthorized();
        row_t rows[$];
        exp_t e;
        rows.push_back(W(16'h1000, 16'h0029, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'h1000, 16'h0037, 1'b1, 1'b0, 8'd0));
        rows.push_back(W(16'h0000, 16'h0018, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(F(16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0030, 16'hE000, 16'hE100, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL unauth[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL unauth[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL unauth[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    task automatic test_dma_early_exit();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE004, 16'h0021, 1'b0, 1'b0, 8'd1));
        rows.push_back(F(16'hE006, 1'b0, 16'h0000, 1'b1, 16'h0022, 16'hE000, 16'hE100, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE010, 16'h0021, 1'b0, 1'b0, 8'd1));
        rows.push_back(R(16'hD000, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE000, 16'h0021, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL dma_exit[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL dma_exit[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL dma_exit[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE001, 16'h0021, 1'b0, 1'b0, 8'd1));
        rows.push_back(W(16'hE100, 16'h0021, 1'b0, 1'b1, 8'd2));
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd2));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE100, 1'b0, 1'b1, 8'd0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL b2b[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL b2b[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL b2b[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    // Checked on dut_b (MAX_ER_CYCLES=16, CNT_W=2); the two pc=0 rows resync dut_a to IDLE.
    task automatic test_timeout_saturation();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        for (int k = 0; k < 16; k++) rows.push_back(R(16'hE010, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE010, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        for (int k = 1; k <= 5; k++) rows.push_back(W(16'hE020, 16'h0021, 1'b0, 1'b0, (k > 3) ? 8'd3 : 8'(k)));
        rows.push_back(R(16'hE100, 1'b0, 1'b1, 8'd3));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_b !== e.viol) begin failures++; $display("FAIL tmo_sat[%0d] viol_reset got=%b exp=%b", i, viol_b, e.viol); end
            if (exec_b !== e.exec) begin failures++; $display("FAIL tmo_sat[%0d] exec_flag got=%b exp=%b", i, exec_b, e.exec); end
            if ({6'd0, wr_cnt_b} !== e.cnt) begin failures++; $display("FAIL tmo_sat[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_b, e.cnt); end
        end
    endtask

    task automatic test_invalid_er();
        row_t rows[$];
        exp_t e;
        rows.push_back(F(16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE100, 16'hE000, 1'b1, 1'b0, 8'd0));
        rows.push_back(F(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE100, 16'hE000, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(F(16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE000, 16'hE000, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(F(16'h1000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hE100, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(F(16'hE030, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE000, 16'hE040, 1'b0, 1'b0, 8'd0));
        rows.push_back(F(16'hE050, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hE000, 16'hE040, 1'b1, 1'b0, 8'd0));
        rows.push_back(R(16'h0000, 1'b0, 1'b0, 8'd0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL bad_er[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL bad_er[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL bad_er[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(16'hA0BE, 1'b0, 1'b0, 8'd0));
        rows.push_back(R(16'hE000, 1'b0, 1'b0, 8'd0));
        rows.push_back(W(16'hE010, 16'h0021, 1'b0, 1'b0, 8'd1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (viol_a !== e.viol) begin failures++; $display("FAIL arst[%0d] viol_reset got=%b exp=%b", i, viol_a, e.viol); end
            if (exec_a !== e.exec) begin failures++; $display("FAIL arst[%0d] exec_flag got=%b exp=%b", i, exec_a, e.exec); end
            if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL arst[%0d] wr_cnt got=%0d exp=%0d", i, wr_cnt_a, e.cnt); end
        end
        // reset lands between clock edges; outputs must follow without an edge
        e.viol = 1'b1; e.exec = 1'b0; e.cnt = 8'd0;
        sb.push_back(e);
        reset_n = 1'b0;
        #2;
        e = sb.pop_front();
        checks += 3;
        if (viol_a !== e.viol) begin failures++; $display("FAIL arst_mid viol_reset got=%b exp=%b", viol_a, e.viol); end
        if (exec_a !== e.exec) begin failures++; $display("FAIL arst_mid exec_flag got=%b exp=%b", exec_a, e.exec); end
        if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL arst_mid wr_cnt got=%0d exp=%0d", wr_cnt_a, e.cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive_row(R(16'h0000, 1'b0, 1'b0, 8'd0));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 2;
        if (viol_a !== e.viol) begin failures++; $display("FAIL arst_clear viol_reset got=%b exp=%b", viol_a, e.viol); end
        if (wr_cnt_a !== e.cnt) begin failures++; $display("FAIL arst_clear wr_cnt got=%0d exp=%0d", wr_cnt_a, e.cnt); end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_unauthorized();
        test_dma_early_exit();
        test_back_to_back();
        test_timeout_saturation();
        test_invalid_er();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
